mem_1r1w_bank_resp: RTL

- Cycle-accurate responder for the t1 bank interface that the multi-port algorithmic memory cores drive: one physical 1R1W SRAM bank (port A write, port B read).
- Integrators instantiate it once per virtual bank under the algo wrappers, so cores and formal/SIM_SVA benches run against real bank timing.
- Models programmable read latency, same-cycle write forwarding, injectable single/double-bit error reporting, and a post-reset clear sweep that gates ready.

---
 rtl/mem_1r1w_bank_resp_if.sv | 32 +++
 rtl/mem_1r1w_bank_resp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_1r1w_bank_resp_if.sv
// Bank-side bundle between an algorithmic memory core (master) and one 1R1W
// bank responder (slave): write port A, read port B, and error injection.
interface mem_1r1w_bank_resp_if #(
    parameter int WIDTH   = 32,
    parameter int BITVROW = 10,
    parameter int BITPADR = 10
);
    logic               ready;
    logic               writeA;
    logic [BITVROW-1:0] addrA;
    logic [WIDTH-1:0]   dinA;
    logic               readB;
    logic [BITVROW-1:0] addrB;
    logic [WIDTH-1:0]   doutB;
    logic               fwrdB;
    logic               serrB;
    logic               derrB;
    logic [BITPADR-1:0] padrB;
    logic               inj_serr;
    logic               inj_derr;
    logic [BITVROW-1:0] inj_addr;

    modport master (
        input  ready, doutB, fwrdB, serrB, derrB, padrB,
        output writeA, addrA, dinA, readB, addrB, inj_serr, inj_derr, inj_addr
    );

    modport slave (
        output ready, doutB, fwrdB, serrB, derrB, padrB,
        input  writeA, addrA, dinA, readB, addrB, inj_serr, inj_derr, inj_addr
    );
endinterface

// File: rtl/mem_1r1w_bank_resp.sv
// Cycle-accurate 1R1W SRAM bank responder: post-reset clear sweep, write-first
// forwarding, programmable read latency and a single injectable error marker.
module mem_1r1w_bank_resp #(
    parameter int WIDTH      = 32,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int BITPADR    = 10,
    parameter int SRAM_DELAY = 2
) (
    input logic                  clk,
    input logic                  rst,
    mem_1r1w_bank_resp_if.slave  bank
);
    // Row index width of the physical array; addresses beyond it are range-checked first.
    localparam int RW = (NUMVROW > 1) ? $clog2(NUMVROW) : 1;
    localparam logic [BITVROW:0] NUMV = (BITVROW+1)'(NUMVROW);
    localparam logic [RW-1:0]    LAST = RW'(NUMVROW - 1);

    typedef enum logic {INIT, READY} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic               fwrd;
        logic               serr;
        logic               derr;
        logic [BITPADR-1:0] padr;
    } res_t;

    state_t           state, next_state;
    logic [RW-1:0]    init_cnt, next_cnt;
    logic             init_we;
    logic             ready_q;
    logic [WIDTH-1:0] mem [NUMVROW];

    logic               mark_valid;
    logic               mark_derr;
    logic [BITVROW-1:0] mark_row;

    logic  wr_in, rd_in, wr_en, rd_en, fwd, hit, inj;
    res_t  cap;
    res_t  pipe [SRAM_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= next_state;
            init_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = init_cnt;
        init_we    = 1'b0;
        case (state)
            INIT: begin
                init_we = 1'b1;
                if (init_cnt == LAST) begin
                    next_state = READY;
                end else begin
                    next_cnt = init_cnt + RW'(1);
                end
            end
            READY: begin
                next_state = READY;
            end
        endcase
    end

    // ready lags the state by one cycle so the last swept row is settled first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state == READY);
        end
    end

    assign wr_in = ({1'b0, bank.addrA} < NUMV);
    assign rd_in = ({1'b0, bank.addrB} < NUMV);
    assign wr_en = ready_q && !rst && bank.writeA && wr_in;
    assign rd_en = ready_q && !rst && bank.readB;
    assign inj   = ready_q && !rst && (bank.inj_serr || bank.inj_derr);
    assign fwd   = wr_en && rd_in && (bank.addrA == bank.addrB);
    assign hit   = mark_valid && rd_in && !fwd && (mark_row == bank.addrB);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we) begin
                mem[init_cnt] <= '0;
            end else if (wr_en) begin
                mem[bank.addrA[RW-1:0]] <= bank.dinA;
            end
        end
    end

    // A fresh injection wins over a same-edge write to the marked row.
    always_ff @(posedge clk) begin
        if (rst) begin
            mark_valid <= 1'b0;
            mark_derr  <= 1'b0;
            mark_row   <= '0;
        end else if (inj) begin
            mark_valid <= 1'b1;
            mark_derr  <= bank.inj_derr;
            mark_row   <= bank.inj_addr;
        end else if (wr_en && mark_valid && (bank.addrA == mark_row)) begin
            mark_valid <= 1'b0;
        end
    end

    always_comb begin
        cap = '0;
        if (rd_en) begin
            cap.padr = BITPADR'(bank.addrB);
            if (fwd) begin
                cap.data = bank.dinA;
                cap.fwrd = 1'b1;
            end else if (rd_in) begin
                cap.data = mem[bank.addrB[RW-1:0]];
                if (hit && mark_derr) begin
                    cap.data[0] = ~cap.data[0];
                    cap.derr    = 1'b1;
                end else if (hit) begin
                    cap.serr = 1'b1;
                end
            end
        end
    end

    // Idle slots carry all-zero entries, so the last stage drives outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SRAM_DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= cap;
            for (int i = 1; i < SRAM_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign bank.ready = ready_q;
    assign bank.doutB = pipe[SRAM_DELAY-1].data;
    assign bank.fwrdB = pipe[SRAM_DELAY-1].fwrd;
    assign bank.serrB = pipe[SRAM_DELAY-1].serr;
    assign bank.derrB = pipe[SRAM_DELAY-1].derr;
    assign bank.padrB = pipe[SRAM_DELAY-1].padr;
endmodule
